// File: rtl/regfile_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_seq_if : dump beat stream (valid/ready) carrying a register pair
// Revision: 1.0
// ---------------------------------------------------------------------------
interface regfile_seq_if #(
   parameter int DW = 32,
   parameter int AW = 5
) ();
   logic          dump_valid;
   logic          dump_ready;
   logic [AW-1:0] dump_s_addr;
   logic [AW-1:0] dump_t_addr;
   logic [DW-1:0] dump_s_data;
   logic [DW-1:0] dump_t_data;

   modport master (
      output dump_valid, dump_s_addr, dump_t_addr, dump_s_data, dump_t_data,
      input  dump_ready
   );

   modport slave (
      input  dump_valid, dump_s_addr, dump_t_addr, dump_s_data, dump_t_data,
      output dump_ready
   );
endinterface
`default_nettype wire

// File: rtl/regfile_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_seq : port arbiter plus hardware fill/dump sequencer for regfile32.
// Optional read-back verify after fill: define REGSEQ_VERIFY_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module regfile_seq #(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int NREG = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_fill,
   input  logic          start_dump,
   input  logic [DW-1:0] fill_base,
   input  logic [DW-1:0] fill_step,
   output logic          busy,
   output logic          done,
   output logic          fill_err,
   input  logic          cpu_D_En,
   input  logic [AW-1:0] cpu_D_Addr,
   input  logic [DW-1:0] cpu_D,
   input  logic [AW-1:0] cpu_S_Addr,
   input  logic [AW-1:0] cpu_T_Addr,
   output logic [DW-1:0] cpu_S,
   output logic [DW-1:0] cpu_T,
   output logic          cpu_stall,
   output logic          rf_D_En,
   output logic [AW-1:0] rf_D_Addr,
   output logic [DW-1:0] rf_D,
   output logic [AW-1:0] rf_S_Addr,
   output logic [AW-1:0] rf_T_Addr,
   input  logic [DW-1:0] rf_S,
   input  logic [DW-1:0] rf_T,
   regfile_seq_if.master dump
);

   localparam logic [AW-1:0] c_ONE       = AW'(1);
   localparam logic [AW-1:0] c_LAST      = AW'(NREG - 1);
   localparam logic [AW-1:0] c_HALF      = AW'(NREG / 2);
   localparam logic [AW-1:0] c_HALF_LAST = AW'(NREG / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FILL     = 3'd1,
`ifdef REGSEQ_VERIFY_EN
      S_VERIFY   = 3'd2,
`endif
      S_DUMP_RD  = 3'd3,
      S_DUMP_OUT = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_idx;
   logic [DW-1:0] r_acc;
   logic [DW-1:0] r_step;
   logic [AW-1:0] r_dump_s_addr;
   logic [AW-1:0] r_dump_t_addr;
   logic [DW-1:0] r_dump_s_data;
   logic [DW-1:0] r_dump_t_data;
`ifdef REGSEQ_VERIFY_EN
   logic [DW-1:0] r_base;
   logic          r_fill_err;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      rf_D_En     = 1'b0;
      rf_D_Addr   = r_idx;
      rf_D        = r_acc;
      rf_S_Addr   = r_idx;
      rf_T_Addr   = r_idx + c_HALF;
      case (r_state)
         S_IDLE: begin
            rf_D_En   = cpu_D_En;
            rf_D_Addr = cpu_D_Addr;
            rf_D      = cpu_D;
            rf_S_Addr = cpu_S_Addr;
            rf_T_Addr = cpu_T_Addr;
            if (start_fill) begin
               w_state_nxt = S_FILL;
            end else if (start_dump) begin
               w_state_nxt = S_DUMP_RD;
            end
         end
         S_FILL: begin
            rf_D_En = 1'b1;
            if (r_idx == c_LAST) begin
`ifdef REGSEQ_VERIFY_EN
               w_state_nxt = S_VERIFY;
`else
               w_state_nxt = S_DONE;
`endif
            end
         end
`ifdef REGSEQ_VERIFY_EN
         S_VERIFY: begin
            if (r_idx == c_LAST) begin
               w_state_nxt = S_DONE;
            end
         end
`endif
         S_DUMP_RD: begin
            w_state_nxt = S_DUMP_OUT;
         end
         S_DUMP_OUT: begin
            if (dump.dump_ready) begin
               w_state_nxt = (r_idx == c_HALF_LAST) ? S_DONE : S_DUMP_RD;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Fill value comes from a running accumulator, so no multiplier is needed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx         <= '0;
         r_acc         <= '0;
         r_step        <= '0;
         r_dump_s_addr <= '0;
         r_dump_t_addr <= '0;
         r_dump_s_data <= '0;
         r_dump_t_data <= '0;
`ifdef REGSEQ_VERIFY_EN
         r_base        <= '0;
         r_fill_err    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_idx <= '0;
               if (start_fill) begin
                  r_acc  <= fill_base;
                  r_step <= fill_step;
`ifdef REGSEQ_VERIFY_EN
                  r_base     <= fill_base;
                  r_fill_err <= 1'b0;
`endif
               end
            end
            S_FILL: begin
               r_idx <= r_idx + c_ONE;
`ifdef REGSEQ_VERIFY_EN
               // Rewind the accumulator so verify regenerates the same series.
               r_acc <= (r_idx == c_LAST) ? r_base : r_acc + r_step;
`else
               r_acc <= r_acc + r_step;
`endif
            end
`ifdef REGSEQ_VERIFY_EN
            S_VERIFY: begin
               r_idx <= r_idx + c_ONE;
               r_acc <= r_acc + r_step;
               if (rf_S != r_acc) begin
                  r_fill_err <= 1'b1;
               end
            end
`endif
            S_DUMP_RD: begin
               r_dump_s_addr <= r_idx;
               r_dump_t_addr <= r_idx + c_HALF;
               r_dump_s_data <= rf_S;
               r_dump_t_data <= rf_T;
            end
            S_DUMP_OUT: begin
               if (dump.dump_ready) begin
                  r_idx <= r_idx + c_ONE;
               end
            end
            S_DONE: begin
               r_idx <= '0;
            end
            default: begin
               r_idx <= '0;
            end
         endcase
      end
   end

   assign busy             = (r_state != S_IDLE);
   assign done             = (r_state == S_DONE);
   assign cpu_stall        = busy;
   assign cpu_S            = rf_S;
   assign cpu_T            = rf_T;
   assign dump.dump_valid  = (r_state == S_DUMP_OUT);
   assign dump.dump_s_addr = r_dump_s_addr;
   assign dump.dump_t_addr = r_dump_t_addr;
   assign dump.dump_s_data = r_dump_s_data;
   assign dump.dump_t_data = r_dump_t_data;
`ifdef REGSEQ_VERIFY_EN
   assign fill_err         = r_fill_err;
`else
   assign fill_err         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_seq : randomized bench for regfile_seq with a behavioural
// register-file reference model and a per-cycle compare process.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_regfile_seq;
   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NREG = 32;
`ifdef REGSEQ_VERIFY_EN
   localparam int c_FILL_CYC = 2 * NREG + 1;
`else
   localparam int c_FILL_CYC = NREG + 1;
`endif

   logic          clk, reset;
   logic          start_fill, start_dump;
   logic [DW-1:0] fill_base, fill_step;
   logic          busy, done, fill_err, cpu_stall;
   logic          cpu_D_En;
   logic [AW-1:0] cpu_D_Addr, cpu_S_Addr, cpu_T_Addr;
   logic [DW-1:0] cpu_D, cpu_S, cpu_T;
   logic          rf_D_En;
   logic [AW-1:0] rf_D_Addr, rf_S_Addr, rf_T_Addr;
   logic [DW-1:0] rf_D, rf_S, rf_T;

   regfile_seq_if #(.DW(DW), .AW(AW)) dif ();

   regfile_seq #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
      .clk(clk), .reset(reset),
      .start_fill(start_fill), .start_dump(start_dump),
      .fill_base(fill_base), .fill_step(fill_step),
      .busy(busy), .done(done), .fill_err(fill_err),
      .cpu_D_En(cpu_D_En), .cpu_D_Addr(cpu_D_Addr), .cpu_D(cpu_D),
      .cpu_S_Addr(cpu_S_Addr), .cpu_T_Addr(cpu_T_Addr),
      .cpu_S(cpu_S), .cpu_T(cpu_T), .cpu_stall(cpu_stall),
      .rf_D_En(rf_D_En), .rf_D_Addr(rf_D_Addr), .rf_D(rf_D),
      .rf_S_Addr(rf_S_Addr), .rf_T_Addr(rf_T_Addr),
      .rf_S(rf_S), .rf_T(rf_T),
      .dump(dif.master)
   );

   // Register file stand-in; 'corrupt' drops writes to register 7.
   logic [DW-1:0] rf_mem [NREG];
   logic          corrupt;
   always @(posedge clk) begin
      if (rf_D_En && !(corrupt && rf_D_Addr == 5'd7)) rf_mem[rf_D_Addr] <= rf_D;
   end
   assign rf_S = rf_mem[rf_S_Addr];
   assign rf_T = rf_mem[rf_T_Addr];

   logic [DW-1:0] exp_mem [NREG];
   logic [DW-1:0] exp_base, exp_step;
   int            dq[$];
   int            checks, errors, wr_cnt, beats;
   logic          mon_en;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : mon
      logic [DW-1:0] w;
      int            n;
      if (mon_en) begin
         chk("stall_eq_busy", {63'd0, cpu_stall}, {63'd0, busy});
         chk("cpu_read_wire", {cpu_S, cpu_T}, {rf_S, rf_T});
         if (!busy) begin
            chk("idle_passthru", {rf_D_En, rf_D_Addr, rf_D, rf_S_Addr, rf_T_Addr},
                {cpu_D_En, cpu_D_Addr, cpu_D, cpu_S_Addr, cpu_T_Addr});
            chk("idle_quiet", {62'd0, dif.dump_valid, done}, 64'd0);
         end else begin
            if (rf_D_En) begin
               wr_cnt++;
               w = exp_base + exp_step * DW'(rf_D_Addr);
               chk("fill_data", rf_D, w);
            end
            if (dif.dump_valid) begin
               if (dq.size() == 0) begin
                  chk("beat_expected", {63'd0, dif.dump_valid}, 64'd0);
               end else begin
                  n = dq[0];
                  chk("beat_addr", {dif.dump_s_addr, dif.dump_t_addr},
                      {AW'(n), AW'(n + NREG / 2)});
                  chk("beat_data", {dif.dump_s_data, dif.dump_t_data},
                      {exp_mem[n], exp_mem[n + NREG / 2]});
                  if (dif.dump_ready) begin
                     void'(dq.pop_front());
                     beats++;
                  end
               end
            end
         end
      end
   end

   task automatic do_fill(input logic [DW-1:0] base, input logic [DW-1:0] step,
                          input bit both, input bit poke);
      int            n;
      logic [DW-1:0] v;
      exp_base   = base;
      exp_step   = step;
      wr_cnt     = 0;
      fill_base  = base;
      fill_step  = step;
      start_fill = 1'b1;
      start_dump = both;
      tick();
      start_fill = 1'b0;
      start_dump = 1'b0;
      fill_base  = $urandom;
      fill_step  = $urandom;
      chk("fill_stall_rise", {63'd0, cpu_stall}, 64'd1);
      if (poke) begin
         cpu_D_En   = 1'b1;
         cpu_D_Addr = 5'd5;
         cpu_D      = 32'hDEAD_BEEF;
      end
      n = 1;
      while (!done && n < 300) begin
         tick();
         n++;
      end
      cpu_D_En = 1'b0;
      chk("fill_done_cycle", 64'(n), 64'(c_FILL_CYC));
      chk("fill_err", {63'd0, fill_err}, {63'd0, corrupt});
      tick();
      chk("fill_idle_after", {62'd0, busy, done}, 64'd0);
      chk("fill_write_count", 64'(wr_cnt), 64'(NREG));
      for (int i = 0; i < NREG; i++) begin
         v = base + step * DW'(i);
         if (!(corrupt && i == 7)) exp_mem[i] = v;
      end
   endtask

   task automatic set_ready(input int mode, input int n);
      case (mode)
         0:       dif.dump_ready = 1'b1;
         1:       dif.dump_ready = ((n / 3) % 2) == 0;
         default: dif.dump_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic do_dump(input int mode);
      int n;
      dq.delete();
      for (int i = 0; i < NREG / 2; i++) dq.push_back(i);
      beats      = 0;
      wr_cnt     = 0;
      start_dump = 1'b1;
      tick();
      start_dump = 1'b0;
      n = 1;
      set_ready(mode, n);
      while (!done && n < 2000) begin
         tick();
         n++;
         set_ready(mode, n);
      end
      dif.dump_ready = 1'b0;
      if (mode == 0) chk("dump_done_cycle", 64'(n), 64'd33);
      chk("dump_beats", 64'(beats), 64'(NREG / 2));
      chk("dump_queue_left", 64'(dq.size()), 64'd0);
      chk("dump_no_writes", 64'(wr_cnt), 64'd0);
      tick();
      chk("dump_idle_after", {63'd0, busy}, 64'd0);
   endtask

   task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      cpu_D_En   = 1'b1;
      cpu_D_Addr = a;
      cpu_D      = d;
      tick();
      cpu_D_En   = 1'b0;
      exp_mem[a] = d;
      cpu_S_Addr = a;
      #1;
      chk("cpu_readback", cpu_S, d);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk(name, {busy, done, fill_err, dif.dump_valid, rf_D_En, cpu_stall,
                 dif.dump_s_addr, dif.dump_t_addr},
          {6'd0, 10'd0});
      chk({name, "_data"}, {dif.dump_s_data, dif.dump_t_data}, 64'd0);
   endtask

   initial begin
      int            m;
      logic [DW-1:0] v;
      checks = 0; errors = 0; wr_cnt = 0; beats = 0;
      mon_en = 1'b0; corrupt = 1'b0;
      reset = 1'b0;
      start_fill = 1'b0; start_dump = 1'b0;
      fill_base = '0; fill_step = '0;
      cpu_D_En = 1'b0; cpu_D_Addr = '0; cpu_D = '0;
      cpu_S_Addr = '0; cpu_T_Addr = '0;
      dif.dump_ready = 1'b0;
      exp_base = '0; exp_step = '0;
      repeat (3) tick();
      chk_reset_outputs("reset_outputs");
      reset = 1'b1;
      tick();
      mon_en = 1'b1;

      do_fill(32'h1000_0000, 32'h0000_0010, 1'b0, 1'b0);
      chk("model_r31", exp_mem[31], 32'h1000_01F0);
      chk("rf_r31", rf_mem[31], 32'h1000_01F0);

      do_fill(32'hFFFF_FFF0, 32'd8, 1'b0, 1'b0);
      chk("rf_r2_wrap", rf_mem[2], 32'h0000_0000);
      chk("rf_r3_wrap", rf_mem[3], 32'h0000_0008);

      do_fill(32'd0, 32'd1, 1'b0, 1'b0);
      chk("model_r20", exp_mem[20], 32'd20);
      do_dump(0);
      do_dump(1);

      // Both starts together, CPU write attempted during the fill.
      do_fill(32'h0BAD_0000, 32'h0000_0100, 1'b1, 1'b1);
      chk("rf_r5_blocked", rf_mem[5], 32'h0BAD_0500);

      for (int it = 0; it < 4; it++) begin
         do_fill($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         for (int k = 0; k < 3; k++) cpu_write(AW'($urandom_range(0, NREG - 1)), $urandom);
         do_dump(2);
      end

`ifdef REGSEQ_VERIFY_EN
      corrupt = 1'b1;
      do_fill(32'hA5A5_0000, 32'd3, 1'b0, 1'b0);
      corrupt = 1'b0;
      do_dump(0);
      do_fill(32'h0000_1000, 32'd4, 1'b0, 1'b0);
`endif

      // Reset in the middle of a fill, at index 10.
      fill_base  = 32'h7777_0000;
      fill_step  = 32'd9;
      exp_base   = fill_base;
      exp_step   = fill_step;
      start_fill = 1'b1;
      tick();
      start_fill = 1'b0;
      m = 0;
      while (!(rf_D_En && busy && rf_D_Addr == 5'd10) && m < 60) begin
         tick();
         m++;
      end
      chk("reach_idx10", 64'(m < 60), 64'd1);
      reset = 1'b0;
      #1;
      chk_reset_outputs("midfill_reset");
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         v = 32'h7777_0000 + 32'd9 * DW'(i);
         exp_mem[i] = v;
      end
      tick();
      do_dump(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/regfile_seq.md
# regfile_seq

Sequencer and port arbiter for the 32-entry register file (`regfile32`). It owns the register file's write port and both read ports. In idle it passes a CPU-side port pair straight through. On command it performs a hardware fill: a programmable arithmetic pattern written to all registers. It also performs a hardware dump: register pairs (i, i+16) streamed out over a valid/ready interface, replacing bench-driven fill/dump loops.

## Interface
Parameters:
- `DW`, 32: data width.
- `AW`, 5: register address width.
- `NREG`, 32: register count; must equal 2**AW and be even.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start_fill`  in  1  fill command, sampled in IDLE.
- `start_dump`  in  1  dump command, sampled in IDLE.
- `fill_base`  in  DW  value written to register 0.
- `fill_step`  in  DW  increment between consecutive registers.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle pulse at end of fill or dump.
- `fill_err`  out  1  sticky verify mismatch flag (see Configuration).
- `cpu_D_En`, `cpu_D_Addr`, `cpu_D`, `cpu_S_Addr`, `cpu_T_Addr`  in  1/AW/DW/AW/AW  CPU port.
- `cpu_S`, `cpu_T`  out  DW  CPU read data; wired to `rf_S`/`rf_T`.
- `cpu_stall`  out  1  equals `busy`.
- `rf_D_En`, `rf_D_Addr`, `rf_D`, `rf_S_Addr`, `rf_T_Addr`  out  1/AW/DW/AW/AW  to register file.
- `rf_S`, `rf_T`  in  DW  combinational read data from register file.
- `dump_valid`  out  1  dump beat available.
- `dump_ready`  in  1  consumer accepts beat.
- `dump_s_addr`, `dump_t_addr`  out  AW  addresses of the beat.
- `dump_s_data`, `dump_t_data`  out  DW  data of the beat.

## Operation
- States: IDLE, FILL, VERIFY (only with the macro), DUMP_RD, DUMP_OUT, DONE.
- IDLE: `rf_*` outputs driven combinationally from `cpu_*`. `start_fill` goes to FILL with index i=0 and latches `fill_base`/`fill_step`. Otherwise `start_dump` goes to DUMP_RD with i=0. Fill wins when both are asserted.
- Start inputs are ignored outside IDLE.
- Outside IDLE, `cpu_D_En` is blocked; the sequencer drives all `rf_*` outputs.
- FILL: `rf_D_En`=1, `rf_D_Addr`=i, `rf_D`=base + i*step mod 2**DW. The accumulator adds step each cycle; no multiplier. After i=NREG-1 go to VERIFY if compiled in, else DONE.
- DUMP_RD: `rf_S_Addr`=i, `rf_T_Addr`=i+NREG/2. Addresses and `rf_S`/`rf_T` are captured into the dump registers. Go to DUMP_OUT.
- DUMP_OUT: `dump_valid`=1, outputs stable until `dump_ready`=1.
  - On acceptance with i=NREG/2-1, go to DONE.
  - On acceptance otherwise, i++ and go to DUMP_RD.
- DONE: `done`=1 for one cycle, then IDLE.
- Reset (any state): IDLE, i=0. Outputs `busy`, `done`, `fill_err`, `dump_valid`, `rf_D_En`, `cpu_stall`, all dump data and address registers are 0. An interrupted fill leaves register contents partially written; this is not an error.

## Timing
- Fill: `start_fill` sampled at edge k.
  - FILL occupies cycles k+1..k+NREG; each write commits at the edge ending its cycle.
  - `done` is high in cycle k+NREG+1; IDLE resumes at k+NREG+2.
- Dump: at least 2 cycles per beat (DUMP_RD + DUMP_OUT with ready high), 16 beats.
  - Minimum 33 cycles from start to `done`.
  - `dump_ready` low stretches DUMP_OUT indefinitely.
- `dump_valid` never drops without acceptance.
- `cpu_stall` rises the cycle after a sampled start and falls the cycle after DONE.

## Configuration
- `REGSEQ_VERIFY_EN` defined:
  - After FILL, VERIFY reads `rf_S_Addr`=i for i=0..NREG-1, one per cycle, and compares `rf_S` with the regenerated expected value.
  - Any mismatch sets `fill_err`. It is cleared only by reset or the next `start_fill`.
  - Adds NREG cycles before DONE.
- Undefined: no VERIFY state, `fill_err` tied 0, FILL goes directly to DONE.

## Test plan
- Fill with base=32'h1000_0000, step=32'h0000_0010 → register 31 = 32'h1000_01F0; `done` exactly NREG+1 cycles after start (2*NREG+1 with verify); `fill_err`=0.
- Fill base=32'hFFFF_FFF0, step=8 → register 2 = 32'h0000_0000, register 3 = 32'h0000_0008 (wrap).
- Dump after fill (base 0, step 1) with `dump_ready` held high → 16 beats, beat n: s_addr=n, s_data=n, t_addr=n+16, t_data=n+16.
- Dump with `dump_ready` toggling every 3 cycles → no beat lost or duplicated; outputs stable while valid and not ready.
- `start_fill` and `start_dump` asserted in the same cycle, then `cpu_D_En`=1 to address 5 during fill → fill runs, CPU write blocked, `cpu_stall`=1.
- Reset asserted at fill index 10 → all outputs 0 immediately; next `start_dump` works normally. With verify compiled in, a forced mismatch sets `fill_err`=1.
